// File: rtl/fsm_state_tracker.sv
// Passive tracker of the 3-bit FSM state bus: one-hot decode, dwell counting and
// transition records via a 2-entry valid/ready queue, sticky illegal/overflow flags.
// Ports: clock, reset (async low), ini (sync low re-init), ea, evt_ready, err_clr ->
//        evt_valid/evt_prev/evt_next/evt_dwell, state_onehot, illegal_err, ovf.
module fsm_state_tracker #(
  parameter int          CNT_W      = 8,
  parameter logic [7:0]  LEGAL_MASK = 8'hFF,
  parameter logic [2:0]  INIT_STATE = 3'b100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ini,
  input  logic [2:0]       ea,
  input  logic             evt_ready,
  input  logic             err_clr,
  output logic             evt_valid,
  output logic [2:0]       evt_prev,
  output logic [2:0]       evt_next,
  output logic [CNT_W-1:0] evt_dwell,
  output logic [7:0]       state_onehot,
  output logic             illegal_err,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic [2:0]       prev;
    logic [2:0]       next;
    logic [CNT_W-1:0] dwell;
  } rec_t;

  logic [2:0]       ea_q;
  logic [CNT_W-1:0] cnt;
  rec_t             slot0;
  rec_t             slot1;
  logic [1:0]       fill;

  rec_t       rec_new;
  rec_t       slot0_d;
  rec_t       slot1_d;
  logic [1:0] fill_d;
  logic       trans;
  logic       push;
  logic       pop;
  logic       drop;
  logic       illegal;

  assign trans   = (ea != ea_q);
  assign push    = trans;
  assign pop     = (fill != 2'd0) && evt_ready;
  assign illegal = !LEGAL_MASK[ea];
  assign rec_new = '{prev: ea_q, next: ea, dwell: cnt};

  // slot0 is the head; with no pop it only loads when the queue is empty,
  // so after draining the outputs keep showing the last record
  always_comb begin
    slot0_d = slot0;
    slot1_d = slot1;
    fill_d  = fill;
    drop    = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (fill == 2'd0) begin
          slot0_d = rec_new;
          fill_d  = 2'd1;
        end else if (fill == 2'd1) begin
          slot1_d = rec_new;
          fill_d  = 2'd2;
        end else begin
          drop = 1'b1;
        end
      end
      2'b01: begin
        if (fill == 2'd2) slot0_d = slot1;
        fill_d = fill - 2'd1;
      end
      2'b11: begin
        if (fill == 2'd2) begin
          slot0_d = slot1;
          slot1_d = rec_new;
        end else begin
          slot0_d = rec_new;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ea_q         <= INIT_STATE;
      cnt          <= '0;
      slot0        <= '0;
      slot1        <= '0;
      fill         <= 2'd0;
      state_onehot <= 8'b1 << INIT_STATE;
      illegal_err  <= 1'b0;
      ovf          <= 1'b0;
    end else if (!ini) begin
      ea_q         <= INIT_STATE;
      cnt          <= '0;
      fill         <= 2'd0;
      state_onehot <= 8'b1 << INIT_STATE;
    end else begin
      ea_q         <= ea;
      state_onehot <= 8'b1 << ea;
      if (trans)
        cnt <= CNT_ONE;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_ONE;
      slot0        <= slot0_d;
      slot1        <= slot1_d;
      fill         <= fill_d;
      // a set in the same cycle as a clear wins
      illegal_err  <= illegal | (illegal_err & ~err_clr);
      ovf          <= drop | (ovf & ~err_clr);
    end
  end

  assign evt_valid = (fill != 2'd0);
  assign evt_prev  = slot0.prev;
  assign evt_next  = slot0.next;
  assign evt_dwell = slot0.dwell;

endmodule

// File: tb/tb_fsm_state_tracker.sv
// Self-checking bench for fsm_state_tracker: directed scenarios then random
// stimulus, compared against a queue-based reference model.
module tb_fsm_state_tracker;

  localparam int         CW    = 4;
  localparam logic [7:0] LMASK = 8'h7F;
  localparam int         SATV  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ini = 1'b1;
  logic [2:0]    ea = 3'd2;
  logic          evt_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          evt_valid;
  logic [2:0]    evt_prev;
  logic [2:0]    evt_next;
  logic [CW-1:0] evt_dwell;
  logic [7:0]    state_onehot;
  logic          illegal_err;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  fsm_state_tracker #(
    .CNT_W(CW),
    .LEGAL_MASK(LMASK),
    .INIT_STATE(3'b100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ini(ini),
    .ea(ea),
    .evt_ready(evt_ready),
    .err_clr(err_clr),
    .evt_valid(evt_valid),
    .evt_prev(evt_prev),
    .evt_next(evt_next),
    .evt_dwell(evt_dwell),
    .state_onehot(state_onehot),
    .illegal_err(illegal_err),
    .ovf(ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    int p;
    int n;
    int d;
  } mrec_t;

  mrec_t mq[$];
  int    m_st;
  int    m_cnt;
  bit    m_ill;
  bit    m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 4;
    m_cnt = 0;
    mq.delete();
    m_ill = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    int    e;
    bit    did_pop;
    bit    bad;
    bit    dropped;
    mrec_t r;
    e = int'(ea);
    if (!ini) begin
      m_st  = 4;
      m_cnt = 0;
      mq.delete();
      return;
    end
    did_pop = (mq.size() > 0) && evt_ready;
    bad     = (LMASK[e] == 1'b0);
    dropped = 0;
    if (did_pop) void'(mq.pop_front());
    if (e != m_st) begin
      r.p = m_st;
      r.n = e;
      r.d = m_cnt;
      if (mq.size() < 2) mq.push_back(r);
      else dropped = 1;
      m_cnt = 1;
    end else if (m_cnt < SATV) begin
      m_cnt = m_cnt + 1;
    end
    m_ill = bad || (m_ill && !err_clr);
    m_ovf = dropped || (m_ovf && !err_clr);
    m_st  = e;
  endtask

  task automatic check_all();
    chk("valid", evt_valid, mq.size() > 0);
    chk("onehot", state_onehot, 32'd1 << m_st);
    chk("illegal", illegal_err, m_ill);
    chk("ovf", ovf, m_ovf);
    if (mq.size() > 0) begin
      chk("prev", evt_prev, mq[0].p);
      chk("next", evt_next, mq[0].n);
      chk("dwell", evt_dwell, mq[0].d);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic go(input logic [2:0] v);
    ea = v;
    step();
  endtask

  initial begin
    // 1. reset with clock running and ea != INIT_STATE
    model_reset();
    ea = 3'd2;
    repeat (3) @(posedge clock);
    #1;
    check_all();
    chk("rst_prev", evt_prev, 0);
    chk("rst_next", evt_next, 0);
    chk("rst_dwell", evt_dwell, 0);
    chk("rst_onehot", state_onehot, 8'h10);
    reset = 1'b1;
    ea = 3'd4;
    repeat (3) step();
    chk("t1_novalid", evt_valid, 0);

    // 2. first transition after three dwell cycles on 4
    evt_ready = 1'b1;
    go(3'd1);
    chk("t2_prev", evt_prev, 4);
    chk("t2_next", evt_next, 1);
    chk("t2_dwell", evt_dwell, 3);
    chk("t2_onehot", state_onehot, 8'h02);
    go(3'd1);
    chk("t2_popped", evt_valid, 0);

    // 3. dwell saturation
    repeat (40) go(3'd1);
    go(3'd5);
    chk("t3_sat", evt_dwell, SATV);

    // 4. backpressure and overflow
    go(3'd4);
    go(3'd4);
    go(3'd4);
    evt_ready = 1'b0;
    go(3'd1);
    go(3'd2);
    go(3'd3);
    chk("t4_ovf", ovf, 1);
    chk("t4_head_prev", evt_prev, 4);
    chk("t4_head_dwell", evt_dwell, 3);
    evt_ready = 1'b1;
    go(3'd3);
    chk("t4_pop_next", evt_next, 2);
    chk("t4_pop_dwell", evt_dwell, 1);
    evt_ready = 1'b0;
    err_clr = 1'b1;
    go(3'd4);
    err_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 0);
    evt_ready = 1'b1;
    go(3'd5);
    chk("t4_pushpop_ovf", ovf, 0);
    chk("t4_pushpop_next", evt_next, 4);
    go(3'd5);
    go(3'd5);
    chk("t4_drained", evt_valid, 0);

    // 5. ini flush
    evt_ready = 1'b0;
    go(3'd6);
    go(3'd1);
    go(3'd2);
    ini = 1'b0;
    go(3'd2);
    chk("t5_flush", evt_valid, 0);
    chk("t5_onehot", state_onehot, 8'h10);
    chk("t5_ovf_kept", ovf, 1);
    ini = 1'b1;
    evt_ready = 1'b1;
    go(3'd4);
    go(3'd4);
    go(3'd6);
    chk("t5_dwell", evt_dwell, 2);

    // 6. illegal code racing err_clr
    err_clr = 1'b1;
    go(3'd7);
    chk("t6_set_wins", illegal_err, 1);
    chk("t6_rec_next", evt_next, 7);
    go(3'd7);
    chk("t6_hold", illegal_err, 1);
    go(3'd0);
    chk("t6_clear", illegal_err, 0);
    err_clr = 1'b0;

    // random phase with one asynchronous reset mid-cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) ea = 3'($urandom_range(0, 7));
      evt_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      ini       = ($urandom_range(0, 19) != 0);
      step();
      if (i == 200) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_valid", evt_valid, 0);
        #1;
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_state_tracker.md
Name: fsm_state_tracker

Overview:
- Passive observer on the 3-bit current-state bus (ea[2:0]) produced by the FSM state register.
- Samples the state every clock and decodes it to one-hot.
- On each state change, emits a transition record: previous code, new code, dwell cycles. Records go out through a 2-entry valid/ready queue to the debug/trace logic.
- Flags illegal state codes and queue overflow with sticky bits.

Parameters:
- CNT_W, 8: width of the dwell counter and evt_dwell; saturating.
- LEGAL_MASK, 8'hFF: bit i = 1 means state code i is legal.
- INIT_STATE, 3'b100: code the state register takes when ini is low; tracker re-init value.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- ini  input  1  synchronous, active-low re-init (same signal the state register uses)
- ea  input  3  current state code from the state register
- evt_ready  input  1  consumer accepts the head record
- err_clr  input  1  synchronous clear of illegal_err and ovf
- evt_valid  output  1  head record valid
- evt_prev  output  3  code before the transition
- evt_next  output  3  code after the transition
- evt_dwell  output  CNT_W  cycles spent in evt_prev
- state_onehot  output  8  registered one-hot of the sampled state
- illegal_err  output  1  sticky: an illegal code was sampled
- ovf  output  1  sticky: a record was dropped

Behaviour:

Reset (reset=0, async):
- ea_q = INIT_STATE, cnt = 0, queue empty.
- evt_valid = 0, evt_prev/evt_next/evt_dwell = 0.
- state_onehot = 8'b0001_0000; illegal_err = 0, ovf = 0.

Priority per clock edge (reset high):
- ini=0 wins over everything else: ea_q <= INIT_STATE, cnt <= 0, queue flushed (evt_valid=0), state_onehot <= one-hot(INIT_STATE).
- ini=0 generates no record; illegal_err/ovf keep their values; evt_ready is ignored.

Sampling (ini=1):
- Every edge: ea_q <= ea, state_onehot <= 1 << ea.
- ea == ea_q: no transition; cnt <= cnt+1, saturating at 2^CNT_W-1.
- ea != ea_q: transition.
  - Push record {prev=ea_q, next=ea, dwell=cnt}.
  - cnt <= 1; the capture edge counts as the first dwell cycle.
- Latency: ea changes before edge T; the record is visible on the outputs after edge T if the queue was empty.
- Legality check on every sampled ea: LEGAL_MASK[ea]==0 sets illegal_err. The record is still pushed normally.

Queue: 2-entry FIFO; outputs show the head entry.
- Pop when evt_valid && evt_ready.
- Push when a transition occurs.
- Push and pop in the same cycle are both performed, including when full: no drop.
- Full with push and no pop: the new record is dropped, ovf <= 1, stored entries unchanged.
- Empty: evt_valid=0; evt_prev/evt_next/evt_dwell hold their last values (don't-care).
- Record order strictly preserved.

Sticky errors:
- err_clr=1 clears illegal_err and ovf.
- A set condition in the same cycle wins: bit reads 1 after the edge.

Async reset mid-operation: all state returns to reset values immediately, independent of clock.

Test Plan:
1. Reset and power-up: assert reset=0 with ea=3'b010 and toggle clock -> evt_valid=0, state_onehot=8'h10, illegal_err=0, ovf=0. Release reset with ea=4 held 3 edges and ini=1 -> cnt reaches 3, no record.
2. Basic dwell: from reset, ea=4 for 3 edges, then ea=1 at edge 4, evt_ready=1 -> one-cycle record after edge 4: prev=4, next=1, dwell=3; state_onehot=8'h02.
3. Saturation: CNT_W=4, ea held 40 edges, then change -> evt_dwell=15.
4. Backpressure and overflow: evt_ready=0; transitions 4->1->2->3 on consecutive edges.
   - Queue holds {4->1, dwell 3}, {1->2, dwell 1}; the third record is dropped, ovf=1.
   - Raising evt_ready pops in order; a push with simultaneous pop while full drops nothing.
5. ini flush: 2 records queued, ini=0 for one edge -> evt_valid=0, state_onehot=8'h10, ovf unchanged. Next record dwell counts from 0 on INIT_STATE.
6. Illegal code with clear race: LEGAL_MASK=8'h7F, ea=7 sampled on the same edge as err_clr=1 -> illegal_err=1 and record pushed. err_clr=1 on the following edge with ea=7 held -> illegal_err stays 1. err_clr=1 with ea=0 -> illegal_err=0.
